// File: rtl/joy_pkg.sv
// Shared types and constants for the remote answer encoder: FSM states,
// idle bus value, player ids and the one-cold answer code map.
package joy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    WAIT_REL
  } joy_state_e;

  localparam logic [7:0] JOY_IDLE = 8'hFF;

  localparam logic [7:0] JOY_P1_A1 = 8'b0111_1111;
  localparam logic [7:0] JOY_P1_A2 = 8'b1011_1111;
  localparam logic [7:0] JOY_P1_A3 = 8'b1101_1111;
  localparam logic [7:0] JOY_P1_A4 = 8'b1110_1111;
  localparam logic [7:0] JOY_P2_A1 = 8'b1111_0111;
  localparam logic [7:0] JOY_P2_A2 = 8'b1111_1011;
  localparam logic [7:0] JOY_P2_A3 = 8'b1111_1101;
  localparam logic [7:0] JOY_P2_A4 = 8'b1111_1110;

  localparam logic [1:0] PLAYER_NONE = 2'd0;
  localparam logic [1:0] PLAYER_1    = 2'd1;
  localparam logic [1:0] PLAYER_2    = 2'd2;

  // Answer number 1..4 from a one-hot button vector (0 if not one-hot).
  function automatic logic [3:0] onehot_to_ans(input logic [3:0] btn);
    logic [3:0] ans;
    ans = 4'd0;
    case (btn)
      4'b0001: ans = 4'd1;
      4'b0010: ans = 4'd2;
      4'b0100: ans = 4'd3;
      4'b1000: ans = 4'd4;
      default: ans = 4'd0;
    endcase
    return ans;
  endfunction

  function automatic logic [7:0] ans_to_code(input logic [1:0] player,
                                             input logic [3:0] ans);
    logic [7:0] code;
    code = JOY_IDLE;
    if (player == PLAYER_1) begin
      case (ans)
        4'd1: code = JOY_P1_A1;
        4'd2: code = JOY_P1_A2;
        4'd3: code = JOY_P1_A3;
        4'd4: code = JOY_P1_A4;
        default: code = JOY_IDLE;
      endcase
    end else if (player == PLAYER_2) begin
      case (ans)
        4'd1: code = JOY_P2_A1;
        4'd2: code = JOY_P2_A2;
        4'd3: code = JOY_P2_A3;
        4'd4: code = JOY_P2_A4;
        default: code = JOY_IDLE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-button debouncer: the output follows the raw input only after the
// raw value has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
module joy_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (raw != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/joy_remote_encoder.sv
// Remote-side answer encoder: debounces 2x4 buttons, launches one one-cold
// code per press, then idles the bus and waits for full release.
// Optional JOY_FAIR_ARB_EN: rotating tie-break between players instead of P1 priority.
module joy_remote_encoder
  import joy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int GAP_CYCLES      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_p1,
  input  logic [3:0] btn_p2,
  input  logic       lock,
  output logic [7:0] hex_joy,
  output logic       busy,
  output logic [1:0] sent_player,
  output logic [3:0] sent_ans
);

  localparam int MAXP = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXP + 1);

  logic [7:0] raw_all;
  logic [7:0] db_all;
  logic [3:0] db_p1, db_p2;

  assign raw_all = {btn_p2, btn_p1};

  for (genvar i = 0; i < 8; i++) begin : g_db
    joy_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .raw (raw_all[i]),
      .db  (db_all[i])
    );
  end

  assign db_p1 = db_all[3:0];
  assign db_p2 = db_all[7:4];

  joy_state_e    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    hex_q, hex_d;
  logic          busy_q, busy_d;
  logic [1:0]    sent_player_q, sent_player_d;
  logic [3:0]    sent_ans_q, sent_ans_d;
`ifdef JOY_FAIR_ARB_EN
  logic          prio_q, prio_d;   // 0: P1 wins next tie, 1: P2 wins next tie
`endif

  logic       cand1, cand2, pick_p2;
  logic [1:0] win_player;
  logic [3:0] win_ans;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hex_d         = hex_q;
    busy_d        = busy_q;
    sent_player_d = sent_player_q;
    sent_ans_d    = sent_ans_q;
`ifdef JOY_FAIR_ARB_EN
    prio_d        = prio_q;
`endif
    cand1      = (onehot_to_ans(db_p1) != 4'd0);
    cand2      = (onehot_to_ans(db_p2) != 4'd0);
    pick_p2    = 1'b0;
    win_player = PLAYER_NONE;
    win_ans    = 4'd0;

    case (state_q)
      IDLE: begin
        hex_d = JOY_IDLE;
        if (!lock && (cand1 || cand2)) begin
`ifdef JOY_FAIR_ARB_EN
          if (cand1 && cand2) begin
            pick_p2 = prio_q;
            prio_d  = ~prio_q;
          end else begin
            pick_p2 = cand2;
          end
`else
          pick_p2 = !cand1;
`endif
          win_player    = pick_p2 ? PLAYER_2 : PLAYER_1;
          win_ans       = onehot_to_ans(pick_p2 ? db_p2 : db_p1);
          hex_d         = ans_to_code(win_player, win_ans);
          sent_player_d = win_player;
          sent_ans_d    = win_ans;
          cnt_d         = '0;
          busy_d        = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (cnt_q == TW'(HOLD_CYCLES - 1)) begin
          hex_d   = JOY_IDLE;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == TW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_REL: begin
        if (db_all == 8'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        hex_d   = JOY_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hex_q         <= JOY_IDLE;
      busy_q        <= 1'b0;
      sent_player_q <= PLAYER_NONE;
      sent_ans_q    <= 4'd0;
`ifdef JOY_FAIR_ARB_EN
      prio_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hex_q         <= hex_d;
      busy_q        <= busy_d;
      sent_player_q <= sent_player_d;
      sent_ans_q    <= sent_ans_d;
`ifdef JOY_FAIR_ARB_EN
      prio_q        <= prio_d;
`endif
    end
  end

  assign hex_joy     = hex_q;
  assign busy        = busy_q;
  assign sent_player = sent_player_q;
  assign sent_ans    = sent_ans_q;

endmodule

// File: tb/tb_joy_remote_encoder.sv
// Bench for joy_remote_encoder: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_joy_remote_encoder;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_p1 = 4'd0;
  logic [3:0] btn_p2 = 4'd0;
  logic       lock = 1'b0;
  logic [7:0] hex_joy;
  logic       busy;
  logic [1:0] sent_player;
  logic [3:0] sent_ans;

  joy_remote_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_p1      (btn_p1),
    .btn_p2      (btn_p2),
    .lock        (lock),
    .hex_joy     (hex_joy),
    .busy        (busy),
    .sent_player (sent_player),
    .sent_ans    (sent_ans)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: debounced state from raw-sample history, FSM from the
  // launch timestamp (code low for HOLD edges, re-arm after HOLD+GAP and release).
  logic [7:0]     m_db;
  logic [DEB-1:0] m_hist [8];
  int             m_seen [8];
  bit             m_active;
  int             m_tl;
  int             cyc = 0;
  logic [7:0]     m_code;
  logic [7:0]     e_hex;
  logic           e_busy;
  logic [1:0]     e_pl;
  logic [3:0]     e_ans;
  bit             m_prio;
  bit             model_ok = 1'b0;

  function automatic int idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] raw, old;
    bit c1, c2, take2;
    int a;
    cyc++;
    raw = {btn_p2, btn_p1};
    if (rst) begin
      m_db     = 8'd0;
      m_active = 1'b0;
      m_prio   = 1'b0;
      e_pl     = 2'd0;
      e_ans    = 4'd0;
      e_hex    = 8'hFF;
      e_busy   = 1'b0;
      for (int b = 0; b < 8; b++) begin
        m_hist[b] = '0;
        m_seen[b] = 0;
      end
      model_ok = 1'b1;
    end else begin
      old = m_db;
      if (!m_active) begin
        c1 = ($countones(old[3:0]) == 1);
        c2 = ($countones(old[7:4]) == 1);
        if (!lock && (c1 || c2)) begin
          take2 = !c1;
`ifdef JOY_FAIR_ARB_EN
          if (c1 && c2) begin
            take2  = m_prio;
            m_prio = !m_prio;
          end
`endif
          a      = idx(take2 ? old[7:4] : old[3:0]) + 1;
          e_pl   = take2 ? 2'd2 : 2'd1;
          e_ans  = 4'(a);
          m_code = take2 ? ~(8'h08 >> (a - 1)) : ~(8'h80 >> (a - 1));
          m_active = 1'b1;
          m_tl     = cyc;
        end
      end else if ((cyc - m_tl) > (HOLD + GAP) && old == 8'd0) begin
        m_active = 1'b0;
      end
      e_hex  = (m_active && (cyc - m_tl) < HOLD) ? m_code : 8'hFF;
      e_busy = m_active;
      for (int b = 0; b < 8; b++) begin
        m_hist[b] = (m_hist[b] << 1) | DEB'(raw[b]);
        if (m_seen[b] < DEB) m_seen[b]++;
        if (m_seen[b] >= DEB && m_hist[b] == {DEB{~m_db[b]}}) begin
          m_db[b]   = ~m_db[b];
          m_seen[b] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (model_ok) begin
      chk("hex_joy", hex_joy, e_hex);
      chk("busy", {7'd0, busy}, {7'd0, e_busy});
      chk("sent_player", {6'd0, sent_player}, {6'd0, e_pl});
      chk("sent_ans", {4'd0, sent_ans}, {4'd0, e_ans});
    end
  end

  task automatic settle();
    @(negedge clk);
    btn_p1 = 4'd0;
    btn_p2 = 4'd0;
    lock   = 1'b0;
    rst    = 1'b0;
    repeat (HOLD + GAP + DEB + 6) @(negedge clk);
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_btn();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 4'(1 << $urandom_range(0, 3));
    if (r < 7) return 4'($urandom_range(0, 15));
    return 4'd0;
  endfunction

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_hex", hex_joy, 8'hFF);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_player", {6'd0, sent_player}, 8'd0);
    rst = 1'b0;

    // 1: clean P1 answer1 press
    @(negedge clk);
    btn_p1 = 4'b0001;
    after_edges(4);
    chk("t1_pre", hex_joy, 8'hFF);
    after_edges(1);
    chk("t1_code", hex_joy, 8'h7F);
    chk("t1_player", {6'd0, sent_player}, 8'd1);
    chk("t1_ans", {4'd0, sent_ans}, 8'd1);
    after_edges(7);
    chk("t1_last_low", hex_joy, 8'h7F);
    after_edges(1);
    chk("t1_released_bus", hex_joy, 8'hFF);
    after_edges(20);
    chk("t1_held_no_repeat", hex_joy, 8'hFF);
    chk("t1_held_busy", {7'd0, busy}, 8'd1);
    @(negedge clk);
    btn_p1 = 4'd0;
    repeat (8) @(negedge clk);
    chk("t1_rearm", {7'd0, busy}, 8'd0);
    settle();

    // 2: bouncing P2 answer4, then steady
    for (int i = 0; i < 10; i++) begin
      btn_p2[3] = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_p2 = 4'b1000;
    after_edges(4);
    chk("t2_pre", hex_joy, 8'hFF);
    after_edges(1);
    chk("t2_code", hex_joy, 8'hFE);
    chk("t2_ans", {4'd0, sent_ans}, 8'd4);
    settle();

    // 3: simultaneous tie, twice
    @(negedge clk);
    btn_p1 = 4'b0100;
    btn_p2 = 4'b0010;
    after_edges(5);
    chk("t3_tie1", hex_joy, 8'hDF);
    chk("t3_tie1_player", {6'd0, sent_player}, 8'd1);
    settle();
    @(negedge clk);
    btn_p1 = 4'b0100;
    btn_p2 = 4'b0010;
    after_edges(5);
`ifdef JOY_FAIR_ARB_EN
    chk("t3_tie2", hex_joy, 8'hFB);
    chk("t3_tie2_player", {6'd0, sent_player}, 8'd2);
`else
    chk("t3_tie2", hex_joy, 8'hDF);
    chk("t3_tie2_player", {6'd0, sent_player}, 8'd1);
`endif
    settle();

    // 4: two buttons from one player
    @(negedge clk);
    btn_p1 = 4'b0011;
    after_edges(30);
    chk("t4_hex", hex_joy, 8'hFF);
    chk("t4_busy", {7'd0, busy}, 8'd0);
    settle();

    // 5: lockout, then unlock while pressed
    @(negedge clk);
    lock   = 1'b1;
    btn_p2 = 4'b0001;
    after_edges(12);
    chk("t5_locked", hex_joy, 8'hFF);
    chk("t5_locked_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    lock = 1'b0;
    after_edges(1);
    chk("t5_unlock", hex_joy, 8'hF7);
    settle();

    // 6: reset in the middle of SEND
    @(negedge clk);
    btn_p1 = 4'b1000;
    after_edges(5);
    chk("t6_code", hex_joy, 8'hEF);
    after_edges(2);
    @(negedge clk);
    rst = 1'b1;
    after_edges(1);
    chk("t6_rst_hex", hex_joy, 8'hFF);
    chk("t6_rst_busy", {7'd0, busy}, 8'd0);
    chk("t6_rst_player", {6'd0, sent_player}, 8'd0);
    chk("t6_rst_ans", {4'd0, sent_ans}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    after_edges(4);
    chk("t6_relaunch_pre", hex_joy, 8'hFF);
    after_edges(1);
    chk("t6_relaunch", hex_joy, 8'hEF);
    chk("t6_relaunch_ans", {4'd0, sent_ans}, 8'd4);
    settle();

    // Random stimulus against the model
    for (int it = 0; it < 120; it++) begin
      @(negedge clk);
      btn_p1 = rand_btn();
      btn_p2 = rand_btn();
      lock   = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 29) == 0);
      if (rst) begin
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/joy_remote_encoder.md
Name: joy_remote_encoder

Overview:
Remote-side transmitter for the 8-bit active-low answer code consumed by the game board's answer checker (min_hex_joy).
- Debounces two players' four answer buttons each.
- Arbitrates one winning press and drives the matching one-cold code for a fixed hold time.
- Returns the bus to idle (8'hFF) and re-arms only after all buttons are released.
- Sits in the joystick/remote enclosure; its hex_joy output wires directly to the main board's joystick input.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable samples required before a raw button change is accepted (>=1)
HOLD_CYCLES, 64, cycles a code is held low on hex_joy (>=1)
GAP_CYCLES, 8, minimum cycles of 8'hFF after a code before re-arm (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
btn_p1  input  4  raw player-1 buttons, active-high; bit0=answer1 .. bit3=answer4
btn_p2  input  4  raw player-2 buttons, active-high; bit0=answer1 .. bit3=answer4
lock  input  1  game-over lockout (score>=5 beep); when 1, no new code is launched
hex_joy  output  8  active-low answer code to game board
busy  output  1  1 in any state other than IDLE
sent_player  output  2  player of last launched code (1 or 2; 0 after reset)
sent_ans  output  4  answer of last launched code (1..4; 0 after reset)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, hex_joy=8'hFF, busy=0, sent_player=0, sent_ans=0, all debounced buttons=0, all counters=0. Reset mid-SEND drops the code to 8'hFF on that same edge.
- Debounce, per button: the debounced value flips only after the raw input has differed from it on DEBOUNCE_CYCLES consecutive edges. Any bounce back resets that button's counter.
- Code map (bit cleared low, all others 1): P1 a1=bit7 (8'b01111111), a2=bit6, a3=bit5, a4=bit4. P2 a1=bit3, a2=bit2, a3=bit1, a4=bit0 (8'b11111110).
- Only single-bit-low codes are ever emitted.
- A player's candidate is valid only when exactly one of that player's debounced buttons is 1. Multiple buttons pressed by one player = no candidate.
- States:
  - IDLE: hex_joy=FF. If lock=0 and any valid candidate exists, latch the winner, drive its code on the next edge, set sent_player/sent_ans, go to SEND. Latency: raw press stable from edge 0 gives debounced=1 at edge DEBOUNCE_CYCLES and hex_joy low at edge DEBOUNCE_CYCLES+1.
  - SEND: hold the code exactly HOLD_CYCLES cycles, ignoring the buttons and lock. Then hex_joy=FF and go to GAP.
  - GAP: hex_joy=FF for GAP_CYCLES cycles, then go to WAIT_REL.
  - WAIT_REL: stay until all 8 debounced buttons are 0, then go to IDLE. Holding a button never repeats a code.
- Simultaneous valid candidates from P1 and P2 on the same IDLE cycle: P1 wins.
- lock=1 in IDLE: stay in IDLE; no code is emitted.
- Counters are sized with $clog2(max param + 1); no wrap occurs within a state.

Optional Feature:
JOY_FAIR_ARB_EN
- Defined: simultaneous P1/P2 valid candidates are resolved by a 1-bit priority flag. The flag resets to P1, and after each simultaneous tie it passes to the loser of that tie. A non-tie launch does not change the flag.
- Undefined: fixed P1 priority as above; no flag register.

Decomposition:
- Package joy_pkg:
  - state enum {IDLE, SEND, GAP, WAIT_REL}
  - JOY_IDLE = 8'hFF
  - code constants per player/answer
  - PLAYER_NONE=0, PLAYER_1=1, PLAYER_2=2
  - function answer-to-code
- One sub-module joy_debounce (single button, parameter DEBOUNCE_CYCLES), instantiated 8 times.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, GAP_CYCLES=2):
1. Reset, then btn_p1=4'b0001 held clean -> hex_joy=8'b01111111 from edge 5 for exactly 8 cycles, then FF; sent_player=1, sent_ans=1; stays FF while the button is held, re-arms after release.
2. btn_p2[3] toggles every 2 cycles for 20 cycles, then held steady -> hex_joy stays FF during bouncing; 8'b11111110 appears 5 edges after the input settles.
3. btn_p1=4'b0100 and btn_p2=4'b0010 rising on the same edge -> 8'b11011111, sent_player=1. With JOY_FAIR_ARB_EN, repeating the tie gives 8'b11111011, sent_player=2.
4. btn_p1=4'b0011 (two buttons), btn_p2=0 -> hex_joy remains FF and busy=0 indefinitely.
5. lock=1, btn_p2=4'b0001 -> hex_joy FF. Dropping lock while still pressed -> 8'b11110111 on the next edge.
6. rst pulsed at cycle 3 of SEND -> hex_joy=FF, busy=0, sent_player=0, sent_ans=0 on that edge; the still-held button re-launches after a full debounce.
